// File: rtl/inta_cycle_master.sv
// CPU-side interrupt-acknowledge initiator: issues the two INTA pulses to the PIC,
// captures the vector during pulse 2 and hands it to the core with valid/taken.
module inta_cycle_master #(
  parameter int PULSE_LOW = 2,
  parameter int GAP       = 1,
  parameter int TIMEOUT   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INT,
  input  logic       int_enable,
  input  logic [7:0] DATA_IN,
  input  logic       IV_ready,
  output logic       INTA,
  output logic [7:0] vector,
  output logic       vec_valid,
  input  logic       vec_taken,
  output logic       spurious,
  output logic [2:0] o_dbg_state
);

  localparam int MAXV = (PULSE_LOW > GAP) ?
                        ((PULSE_LOW > TIMEOUT) ? PULSE_LOW : TIMEOUT) :
                        ((GAP > TIMEOUT) ? GAP : TIMEOUT);
  localparam int CW = $clog2(MAXV + 1);
  localparam logic [CW:0] L_PL  = (CW+1)'(PULSE_LOW);
  localparam logic [CW:0] L_GAP = (CW+1)'(GAP);
  localparam logic [CW:0] L_TO  = (CW+1)'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACK1  = 3'd1,
    S_GAP1  = 3'd2,
    S_ACK2  = 3'd3,
    S_RECOV = 3'd4
  } state_t;

  // Handshake to the core: vec_valid rises with the closing INTA edge and
  // holds vector stable until an edge samples vec_taken=1 while valid.
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_inta;
  logic [7:0]      r_vector;
  logic            r_vec_valid;
  logic            r_spurious;
  logic            r_got;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW:0]     w_elapsed;
  logic            w_inta_nxt;
  logic [7:0]      w_vector_nxt;
  logic            w_valid_nxt;
  logic            w_spurious_nxt;
  logic            w_got_nxt;

  // w_elapsed is the number of cycles spent in the current state including this one.
  assign w_elapsed = {1'b0, r_cnt} + (CW+1)'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = w_elapsed[CW-1:0];
    w_inta_nxt     = r_inta;
    w_vector_nxt   = r_vector;
    w_valid_nxt    = r_vec_valid & ~vec_taken;
    w_spurious_nxt = 1'b0;
    w_got_nxt      = r_got;
    case (r_state)
      S_IDLE: begin
        w_inta_nxt = 1'b1;
        w_cnt_nxt  = '0;
        if (INT && int_enable && !r_vec_valid) begin
          w_state_nxt = S_ACK1;
          w_inta_nxt  = 1'b0;
        end
      end
      S_ACK1: begin
        if (w_elapsed >= L_PL) begin
          w_state_nxt = S_GAP1;
          w_inta_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      S_GAP1: begin
        if (w_elapsed >= L_GAP) begin
          w_state_nxt = S_ACK2;
          w_inta_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_got_nxt   = 1'b0;
        end
      end
      S_ACK2: begin
        // Timeout takes precedence over a capture arriving on the same edge.
        if (r_got && (w_elapsed >= L_PL)) begin
          w_state_nxt = S_RECOV;
          w_inta_nxt  = 1'b1;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else if (!r_got && (w_elapsed >= L_TO)) begin
          w_state_nxt    = S_RECOV;
          w_inta_nxt     = 1'b1;
          w_spurious_nxt = 1'b1;
          w_cnt_nxt      = '0;
        end else if (!r_got && IV_ready) begin
          w_vector_nxt = DATA_IN;
          w_got_nxt    = 1'b1;
        end
      end
      S_RECOV: begin
        w_inta_nxt = 1'b1;
        if (w_elapsed >= L_GAP) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_inta_nxt  = 1'b1;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_inta      <= 1'b1;
      r_vector    <= 8'h00;
      r_vec_valid <= 1'b0;
      r_spurious  <= 1'b0;
      r_got       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_inta      <= w_inta_nxt;
      r_vector    <= w_vector_nxt;
      r_vec_valid <= w_valid_nxt;
      r_spurious  <= w_spurious_nxt;
      r_got       <= w_got_nxt;
    end
  end

  assign INTA        = r_inta;
  assign vector      = r_vector;
  assign vec_valid   = r_vec_valid;
  assign spurious    = r_spurious;
  assign o_dbg_state = r_state;

endmodule
